pic_bus_interface_seq: RTL and testbench
========================================

Name: pic_bus_interface_seq

Overview:
- Parametrised bus interface and initialisation sequencer for the 8259A-compatible PIC.
- Synchronises the asynchronous CPU strobes (cs_n, rd_n, wr_n) and buffers write data and the A0 address bit.
- Detects write completion on the rising edge of wr_n.
- Tracks the ICW1→ICW2→[ICW3]→[ICW4] initialisation sequence with an FSM, then issues exactly one registered strobe per accepted command word. Illegal writes are flagged instead of decoded.
- Sits between the external CPU pins and the PIC register and control blocks (IMR, priority resolver, cascade logic).

Parameters:
- DATA_WIDTH, 8, width of the data bus. Must be ≥ 8; bits [4:0] carry the command decode fields.
- SYNC_STAGES, 2, flip-flop depth of the cs_n/rd_n/wr_n synchronisers. 0 means inputs are registered once without metastability protection.
- CASCADE_EN, 1, when 0 ICW3 is never expected regardless of ICW1.SNGL.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- a0  in  1  address bit A0
- data_bus_in  in  DATA_WIDTH  CPU write data
- internal_data_bus  out  DATA_WIDTH  captured write data, held until next write
- write_icw1 / write_icw2 / write_icw3 / write_icw4  out  1 each  one-cycle command-word strobes
- write_ocw1 / write_ocw2 / write_ocw3  out  1 each  one-cycle command-word strobes
- ignored_write  out  1  one-cycle pulse when a completed write is not legal in the current state
- init_done  out  1  high in READY state
- single_mode  out  1  latched ICW1.D1 (SNGL)
- icw4_needed  out  1  latched ICW1.D0 (IC4)
- read  out  1  level: synchronised ~rd_n & ~cs_n
- read_isr_sel  out  1  read-back select, 0 = IRR, 1 = ISR

Behaviour:
- Reset (asynchronous, active-high):
  - All strobes, ignored_write, read, init_done, single_mode, icw4_needed and read_isr_sel go to 0.
  - internal_data_bus goes to 0.
  - FSM goes to IDLE.
  - Synchroniser stages for cs_n/rd_n/wr_n go to 1 (inactive).
  - Reset asserted mid-sequence abandons the sequence; no strobe is emitted for an in-flight write.
- Alignment: data_bus_in and a0 pass through a SYNC_STAGES-deep plain delay pipeline so they stay aligned with the synchronised strobes (cs_s, wr_s, rd_s).
- Capture:
  - internal_data_bus and the address latch update on every clock where cs_s = 0 and wr_s = 0.
  - Otherwise they hold.
- Write-complete detection:
  - prev_wr is a register, forced to 1 when cs_s = 1, else it follows wr_s.
  - A write completes when prev_wr = 0 and wr_s = 1.
  - Strobes are registered and fire one cycle after completion.
  - Latency: for SYNC_STAGES = S, the strobe is high during cycle S+2 counted from the first clock edge that samples wr_n = 1.
  - If cs_n deasserts before wr_n rises (cs_s high while wr_s is low), the write is aborted: no strobe and no ignored_write.
- Decode on write completion (D = internal_data_bus, A = latched a0):
  - A=0, D[4]=1: ICW1, accepted in any state.
    - single_mode ← D[1]; icw4_needed ← D[0]; read_isr_sel ← 0; init_done ← 0.
    - Next state EXP_ICW2.
  - EXP_ICW2, A=1: ICW2.
    - Next state: EXP_ICW3 if (CASCADE_EN & ~single_mode).
    - Else EXP_ICW4 if icw4_needed.
    - Else READY.
  - EXP_ICW3, A=1: ICW3. Next state EXP_ICW4 if icw4_needed, else READY.
  - EXP_ICW4, A=1: ICW4. Next state READY.
  - READY, A=1: OCW1.
  - READY, A=0, D[4:3]=00: OCW2.
  - READY, A=0, D[4:3]=01: OCW3. If D[1] (RR) = 1, read_isr_sel ← D[0] (RIS); otherwise read_isr_sel holds.
  - All other completed writes (IDLE with a non-ICW1 word; A=0/D[4]=0 in an EXP_* state): ignored_write pulses, no state change, no strobe.
- At most one strobe or ignored_write is active in any cycle.
- init_done = (state == READY), registered.
- read is combinational from the synchronised signals. It is independent of FSM state and has no side effects.
- Back-to-back writes: a new write may begin the cycle after completion. Each completion is evaluated against the state left by the previous one.

Test Plan:
- Reset, then ICW1 = 0x13, ICW2 = 0x20, ICW4 = 0x01 (SNGL=1, IC4=1) → write_icw1, write_icw2, write_icw4 each pulse exactly once; no write_icw3; init_done = 1 after ICW4; single_mode = 1; icw4_needed = 1.
- Cascade: ICW1 = 0x11, ICW2 = 0x08, ICW3 = 0x04, ICW4 = 0x01 → all four ICW strobes in order. Repeat with CASCADE_EN = 0 → the 0x04 write at A=1 is taken as ICW4 and init_done = 1 after the third write.
- READY: write A=1 0xFB → write_ocw1, internal_data_bus = 0xFB. A=0 0x20 → write_ocw2. A=0 0x0B → write_ocw3, read_isr_sel = 1. A=0 0x08 → read_isr_sel stays 1.
- IDLE after reset: write A=1 0xFF → ignored_write pulses, no strobe, init_done = 0. Then ICW1 = 0x17 while READY → write_icw1, init_done drops to 0, read_isr_sel = 0.
- Abort: cs_n rises 2 cycles before wr_n rises → no strobe, no ignored_write. Measure strobe latency for SYNC_STAGES ∈ {0, 2, 3} = S+2 cycles after wr_n rise.
- Assert reset while in EXP_ICW3 with a write in flight → all outputs 0, FSM in IDLE, no strobe after release. Next A=1 write → ignored_write.

Source files
------------

// File: rtl/pic_bus_interface_seq.sv
// ----------------------------------------------------------------------------
// pic_bus_interface_seq
// CPU bus interface and initialisation sequencer for an 8259A-compatible PIC.
// It synchronises the CPU strobes and delays data/A0 by the same amount so the
// two stay aligned. It detects the end of each write on the rising edge of
// wr_n. It tracks the ICW1 -> ICW2 -> [ICW3] -> [ICW4] sequence and then emits
// one registered strobe per accepted command word. A write that is not legal
// in the current state produces an ignored_write pulse instead of a strobe.
//
// Ports:
//   clock, reset        system clock; asynchronous active-high reset
//   cs_n, rd_n, wr_n    asynchronous CPU strobes, active low
//   a0, data_bus_in     CPU address bit and write data
//   internal_data_bus   last captured write data
//   write_icw1..4       one-cycle strobes for the initialisation words
//   write_ocw1..3       one-cycle strobes for the operation words
//   ignored_write       one-cycle pulse for an illegal completed write
//   init_done           high while the sequencer is ready for OCWs
//   single_mode         latched ICW1.SNGL
//   icw4_needed         latched ICW1.IC4
//   read                synchronised read strobe (level)
//   read_isr_sel        read-back select: 0 = IRR, 1 = ISR
// ----------------------------------------------------------------------------
module pic_bus_interface_seq #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          CASCADE_EN  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic                  a0,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_icw1,
    output logic                  write_icw2,
    output logic                  write_icw3,
    output logic                  write_icw4,
    output logic                  write_ocw1,
    output logic                  write_ocw2,
    output logic                  write_ocw3,
    output logic                  ignored_write,
    output logic                  init_done,
    output logic                  single_mode,
    output logic                  icw4_needed,
    output logic                  read,
    output logic                  read_isr_sel
);

    typedef enum logic [2:0] {
        StIdle,
        StExpIcw2,
        StExpIcw3,
        StExpIcw4,
        StReady
    } state_e;

    // An input register plus SYNC_STAGES synchroniser flops; with 0 stages the
    // pins are still registered once. Data and A0 use the same depth.
    localparam int unsigned Depth = SYNC_STAGES + 1;

    logic [SYNC_STAGES:0]  cs_pipe_q, rd_pipe_q, wr_pipe_q, a0_pipe_q;
    logic [DATA_WIDTH-1:0] data_pipe_q [Depth];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_pipe_q <= '1;
            rd_pipe_q <= '1;
            wr_pipe_q <= '1;
            a0_pipe_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                data_pipe_q[i] <= '0;
            end
        end else begin
            cs_pipe_q[0]   <= cs_n;
            rd_pipe_q[0]   <= rd_n;
            wr_pipe_q[0]   <= wr_n;
            a0_pipe_q[0]   <= a0;
            data_pipe_q[0] <= data_bus_in;
            for (int unsigned i = 1; i < Depth; i++) begin
                cs_pipe_q[i]   <= cs_pipe_q[i-1];
                rd_pipe_q[i]   <= rd_pipe_q[i-1];
                wr_pipe_q[i]   <= wr_pipe_q[i-1];
                a0_pipe_q[i]   <= a0_pipe_q[i-1];
                data_pipe_q[i] <= data_pipe_q[i-1];
            end
        end
    end

    logic                  cs_s, rd_s, wr_s, a0_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign cs_s   = cs_pipe_q[SYNC_STAGES];
    assign rd_s   = rd_pipe_q[SYNC_STAGES];
    assign wr_s   = wr_pipe_q[SYNC_STAGES];
    assign a0_s   = a0_pipe_q[SYNC_STAGES];
    assign data_s = data_pipe_q[SYNC_STAGES];

    assign read = ~rd_s & ~cs_s;

    logic                  prev_wr_q;
    logic [DATA_WIDTH-1:0] bus_q;
    logic                  a0_q;
    logic                  wr_done;

    // Forcing prev_wr high while deselected means a write whose chip select
    // drops before wr_n rises never completes.
    assign wr_done = ~prev_wr_q & wr_s;

    state_e     state_q, state_d;
    logic [3:0] icw_q, icw_d;
    logic [2:0] ocw_q, ocw_d;
    logic       ignored_q, ignored_d;
    logic       single_q, single_d;
    logic       ic4_q, ic4_d;
    logic       isr_q, isr_d;
    logic       init_q, init_d;

    always_comb begin
        state_d   = state_q;
        icw_d     = '0;
        ocw_d     = '0;
        ignored_d = 1'b0;
        single_d  = single_q;
        ic4_d     = ic4_q;
        isr_d     = isr_q;
        if (wr_done) begin
            if (!a0_q && bus_q[4]) begin
                // ICW1 restarts initialisation from any state.
                icw_d[0] = 1'b1;
                single_d = bus_q[1];
                ic4_d    = bus_q[0];
                isr_d    = 1'b0;
                state_d  = StExpIcw2;
            end else begin
                unique case (state_q)
                    StExpIcw2: begin
                        if (a0_q) begin
                            icw_d[1] = 1'b1;
                            if (CASCADE_EN && !single_q) state_d = StExpIcw3;
                            else if (ic4_q)              state_d = StExpIcw4;
                            else                         state_d = StReady;
                        end else begin
                            ignored_d = 1'b1;
                        end
                    end
                    StExpIcw3: begin
                        if (a0_q) begin
                            icw_d[2] = 1'b1;
                            state_d  = ic4_q ? StExpIcw4 : StReady;
                        end else begin
                            ignored_d = 1'b1;
                        end
                    end
                    StExpIcw4: begin
                        if (a0_q) begin
                            icw_d[3] = 1'b1;
                            state_d  = StReady;
                        end else begin
                            ignored_d = 1'b1;
                        end
                    end
                    StReady: begin
                        if (a0_q) begin
                            ocw_d[0] = 1'b1;
                        end else if (!bus_q[3]) begin
                            ocw_d[1] = 1'b1;
                        end else begin
                            ocw_d[2] = 1'b1;
                            // RR selects whether RIS updates the read-back choice.
                            if (bus_q[1]) isr_d = bus_q[0];
                        end
                    end
                    default: ignored_d = 1'b1;
                endcase
            end
        end
        init_d = (state_d == StReady);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_wr_q <= 1'b1;
            bus_q     <= '0;
            a0_q      <= 1'b0;
            state_q   <= StIdle;
            icw_q     <= '0;
            ocw_q     <= '0;
            ignored_q <= 1'b0;
            single_q  <= 1'b0;
            ic4_q     <= 1'b0;
            isr_q     <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            prev_wr_q <= cs_s ? 1'b1 : wr_s;
            if (!cs_s && !wr_s) begin
                bus_q <= data_s;
                a0_q  <= a0_s;
            end
            state_q   <= state_d;
            icw_q     <= icw_d;
            ocw_q     <= ocw_d;
            ignored_q <= ignored_d;
            single_q  <= single_d;
            ic4_q     <= ic4_d;
            isr_q     <= isr_d;
            init_q    <= init_d;
        end
    end

    assign internal_data_bus = bus_q;
    assign write_icw1        = icw_q[0];
    assign write_icw2        = icw_q[1];
    assign write_icw3        = icw_q[2];
    assign write_icw4        = icw_q[3];
    assign write_ocw1        = ocw_q[0];
    assign write_ocw2        = ocw_q[1];
    assign write_ocw3        = ocw_q[2];
    assign ignored_write     = ignored_q;
    assign init_done         = init_q;
    assign single_mode       = single_q;
    assign icw4_needed       = ic4_q;
    assign read_isr_sel      = isr_q;

endmodule

// File: tb/tb_pic_bus_interface_seq.sv
// Bench for pic_bus_interface_seq. Three instances share the stimulus:
//   dut_a: SYNC_STAGES=2, CASCADE_EN=1 (checked through the scoreboard)
//   dut_b: SYNC_STAGES=0, CASCADE_EN=0
//   dut_c: SYNC_STAGES=3, CASCADE_EN=1
// Event vector bits: {ignored, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}.
module tb_pic_bus_interface_seq;

    localparam logic [7:0] EvIcw1 = 8'h01;
    localparam logic [7:0] EvIcw2 = 8'h02;
    localparam logic [7:0] EvIcw3 = 8'h04;
    localparam logic [7:0] EvIcw4 = 8'h08;
    localparam logic [7:0] EvOcw1 = 8'h10;
    localparam logic [7:0] EvOcw2 = 8'h20;
    localparam logic [7:0] EvOcw3 = 8'h40;
    localparam logic [7:0] EvIgn  = 8'h80;

    typedef struct packed {
        logic       a;
        logic [7:0] d;
        logic [7:0] ea;  // expected event for dut_a / dut_c
        logic [7:0] eb;  // expected event for dut_b
    } row_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [7:0] data_bus_in = 8'h00;

    wire [7:0] ev_a, ev_b, ev_c, bus_a, bus_b, bus_c;
    wire       init_a, init_b, init_c, single_a, single_b, single_c;
    wire       ic4_a, ic4_b, ic4_c, read_a, read_b, read_c, isr_a, isr_b, isr_c;

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] sb[$];

    always #5 clock = ~clock;

    pic_bus_interface_seq #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CASCADE_EN(1'b1)) dut_a (
        .clock(clock), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_bus_in(data_bus_in), .internal_data_bus(bus_a),
        .write_icw1(ev_a[0]), .write_icw2(ev_a[1]), .write_icw3(ev_a[2]), .write_icw4(ev_a[3]),
        .write_ocw1(ev_a[4]), .write_ocw2(ev_a[5]), .write_ocw3(ev_a[6]),
        .ignored_write(ev_a[7]), .init_done(init_a), .single_mode(single_a),
        .icw4_needed(ic4_a), .read(read_a), .read_isr_sel(isr_a));

    pic_bus_interface_seq #(.DATA_WIDTH(8), .SYNC_STAGES(0), .CASCADE_EN(1'b0)) dut_b (
        .clock(clock), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_bus_in(data_bus_in), .internal_data_bus(bus_b),
        .write_icw1(ev_b[0]), .write_icw2(ev_b[1]), .write_icw3(ev_b[2]), .write_icw4(ev_b[3]),
        .write_ocw1(ev_b[4]), .write_ocw2(ev_b[5]), .write_ocw3(ev_b[6]),
        .ignored_write(ev_b[7]), .init_done(init_b), .single_mode(single_b),
        .icw4_needed(ic4_b), .read(read_b), .read_isr_sel(isr_b));

    pic_bus_interface_seq #(.DATA_WIDTH(8), .SYNC_STAGES(3), .CASCADE_EN(1'b1)) dut_c (
        .clock(clock), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_bus_in(data_bus_in), .internal_data_bus(bus_c),
        .write_icw1(ev_c[0]), .write_icw2(ev_c[1]), .write_icw3(ev_c[2]), .write_icw4(ev_c[3]),
        .write_ocw1(ev_c[4]), .write_ocw2(ev_c[5]), .write_ocw3(ev_c[6]),
        .ignored_write(ev_c[7]), .init_done(init_c), .single_mode(single_c),
        .icw4_needed(ic4_c), .read(read_c), .read_isr_sel(isr_c));

    // Scoreboard monitor for dut_a: every cycle with an event pops one entry.
    always @(negedge clock) begin
        if (ev_a != 8'h00) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got ev=%h bus=%h, want no event", ev_a, bus_a);
            end else begin
                logic [15:0] exp_e;
                exp_e = sb.pop_front();
                if ({ev_a, bus_a} !== exp_e)
                    $display("FAIL sb_event: got ev=%h bus=%h, want ev=%h bus=%h",
                             ev_a, bus_a, exp_e[15:8], exp_e[7:0]);
                else n_pass++;
            end
        end
    end

    // Drives one complete write and collects the events seen on dut_b and dut_c.
    task automatic do_write(input logic a, input logic [7:0] d, input logic [7:0] ea,
                            output logic [7:0] seen_b, output logic [7:0] seen_c);
        sb.push_back({ea, d});
        @(posedge clock); #1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; data_bus_in = d;
        repeat (3) @(posedge clock);
        #1;
        wr_n = 1'b1; cs_n = 1'b1;
        seen_b = 8'h00; seen_c = 8'h00;
        repeat (8) begin
            @(negedge clock);
            seen_b |= ev_b; seen_c |= ev_c;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if ({ev_a, bus_a, init_a, single_a, ic4_a, isr_a, read_a} !== 21'd0)
            $display("FAIL reset_a: got %h, want 0",
                     {ev_a, bus_a, init_a, single_a, ic4_a, isr_a, read_a});
        else n_pass++;
        n_total++;
        if ({ev_b, bus_b, init_b, single_b, ic4_b, isr_b, read_b} !== 21'd0)
            $display("FAIL reset_b: got %h, want 0",
                     {ev_b, bus_b, init_b, single_b, ic4_b, isr_b, read_b});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_read();
        @(posedge clock); #1;
        cs_n = 1'b0; rd_n = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        n_total++;
        if ({read_a, read_b, read_c} !== 3'b111)
            $display("FAIL read_high: got %b, want 111", {read_a, read_b, read_c});
        else n_pass++;
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        n_total++;
        if ({read_a, read_b, read_c} !== 3'b000)
            $display("FAIL read_low: got %b, want 000", {read_a, read_b, read_c});
        else n_pass++;
    endtask

    task automatic run_rows_note(input string name, input int n);
        // Only reports progress; checks stay in each test task.
        $display("running %s (%0d writes)", name, n);
    endtask

    task automatic test_idle_ignored();
        logic [7:0] sbv, scv;
        do_write(1'b1, 8'hFF, EvIgn, sbv, scv);
        n_total++;
        if (sbv !== EvIgn) $display("FAIL idle_ign_b: got %h, want %h", sbv, EvIgn);
        else n_pass++;
        n_total++;
        if ({init_a, init_b, init_c} !== 3'b000)
            $display("FAIL idle_init: got %b, want 000", {init_a, init_b, init_c});
        else n_pass++;
    endtask

    task automatic test_single();
        row_t rows [3];
        logic [7:0] sbv, scv;
        rows[0] = '{a: 1'b0, d: 8'h13, ea: EvIcw1, eb: EvIcw1};
        rows[1] = '{a: 1'b1, d: 8'h20, ea: EvIcw2, eb: EvIcw2};
        rows[2] = '{a: 1'b1, d: 8'h01, ea: EvIcw4, eb: EvIcw4};
        run_rows_note("test_single", 3);
        for (int i = 0; i < 3; i++) begin
            do_write(rows[i].a, rows[i].d, rows[i].ea, sbv, scv);
            n_total++;
            if (sbv !== rows[i].eb)
                $display("FAIL single_b row %0d: got %h, want %h", i, sbv, rows[i].eb);
            else n_pass++;
            n_total++;
            if (scv !== rows[i].ea)
                $display("FAIL single_c row %0d: got %h, want %h", i, scv, rows[i].ea);
            else n_pass++;
        end
        n_total++;
        if ({init_a, single_a, ic4_a, init_b, single_b, ic4_b} !== 6'b111111)
            $display("FAIL single_flags: got %b, want 111111",
                     {init_a, single_a, ic4_a, init_b, single_b, ic4_b});
        else n_pass++;
    endtask

    task automatic test_ready_ocw();
        row_t rows [4];
        logic [7:0] sbv, scv;
        rows[0] = '{a: 1'b1, d: 8'hFB, ea: EvOcw1, eb: EvOcw1};
        rows[1] = '{a: 1'b0, d: 8'h20, ea: EvOcw2, eb: EvOcw2};
        rows[2] = '{a: 1'b0, d: 8'h0B, ea: EvOcw3, eb: EvOcw3};
        rows[3] = '{a: 1'b0, d: 8'h08, ea: EvOcw3, eb: EvOcw3};
        for (int i = 0; i < 4; i++) begin
            do_write(rows[i].a, rows[i].d, rows[i].ea, sbv, scv);
            n_total++;
            if (sbv !== rows[i].eb || bus_b !== rows[i].d)
                $display("FAIL ocw_b row %0d: got ev=%h bus=%h, want ev=%h bus=%h",
                         i, sbv, bus_b, rows[i].eb, rows[i].d);
            else n_pass++;
            if (i >= 2) begin
                n_total++;
                if ({isr_a, isr_b, isr_c} !== 3'b111)
                    $display("FAIL ocw3_isr row %0d: got %b, want 111", i,
                             {isr_a, isr_b, isr_c});
                else n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        int lat_a = 0, lat_b = 0, lat_c = 0;
        sb.push_back({EvOcw1, 8'h5A});
        @(posedge clock); #1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_bus_in = 8'h5A;
        repeat (3) @(posedge clock);
        #1;
        wr_n = 1'b1; cs_n = 1'b1;
        // Edge k = 1 is the first edge that samples wr_n high.
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (ev_a != 8'h00 && lat_a == 0) lat_a = k;
            if (ev_b != 8'h00 && lat_b == 0) lat_b = k;
            if (ev_c != 8'h00 && lat_c == 0) lat_c = k;
        end
        n_total++;
        if (lat_b != 2) $display("FAIL latency_s0: got %0d, want 2", lat_b);
        else n_pass++;
        n_total++;
        if (lat_a != 4) $display("FAIL latency_s2: got %0d, want 4", lat_a);
        else n_pass++;
        n_total++;
        if (lat_c != 5) $display("FAIL latency_s3: got %0d, want 5", lat_c);
        else n_pass++;
    endtask

    task automatic test_reicw1();
        logic [7:0] sbv, scv;
        do_write(1'b0, 8'h17, EvIcw1, sbv, scv);
        n_total++;
        if (sbv !== EvIcw1) $display("FAIL reicw1_b: got %h, want %h", sbv, EvIcw1);
        else n_pass++;
        n_total++;
        if ({init_a, init_b, isr_a, isr_b, single_a} !== 5'b00001)
            $display("FAIL reicw1_flags: got %b, want 00001",
                     {init_a, init_b, isr_a, isr_b, single_a});
        else n_pass++;
    endtask

    task automatic test_cascade();
        row_t rows [4];
        logic [7:0] sbv, scv;
        rows[0] = '{a: 1'b0, d: 8'h11, ea: EvIcw1, eb: EvIcw1};
        rows[1] = '{a: 1'b1, d: 8'h08, ea: EvIcw2, eb: EvIcw2};
        rows[2] = '{a: 1'b1, d: 8'h04, ea: EvIcw3, eb: EvIcw4};
        rows[3] = '{a: 1'b1, d: 8'h01, ea: EvIcw4, eb: EvOcw1};
        for (int i = 0; i < 4; i++) begin
            do_write(rows[i].a, rows[i].d, rows[i].ea, sbv, scv);
            n_total++;
            if (sbv !== rows[i].eb)
                $display("FAIL cascade_b row %0d: got %h, want %h", i, sbv, rows[i].eb);
            else n_pass++;
            n_total++;
            if (scv !== rows[i].ea)
                $display("FAIL cascade_c row %0d: got %h, want %h", i, scv, rows[i].ea);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if ({init_a, init_b, single_a} !== 3'b010)
                    $display("FAIL cascade_mid: got %b, want 010", {init_a, init_b, single_a});
                else n_pass++;
            end
        end
        n_total++;
        if ({init_a, init_b, init_c} !== 3'b111)
            $display("FAIL cascade_done: got %b, want 111", {init_a, init_b, init_c});
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] sbv = 8'h00, scv = 8'h00;
        @(posedge clock); #1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_bus_in = 8'h55;
        repeat (3) @(posedge clock);
        #1;
        cs_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        wr_n = 1'b1;
        repeat (10) begin
            @(negedge clock);
            sbv |= ev_b; scv |= ev_c;
        end
        n_total++;
        if ({sbv, scv} !== 16'h0000)
            $display("FAIL abort: got b=%h c=%h, want 00 00", sbv, scv);
        else n_pass++;
    endtask

    task automatic test_reset_midseq();
        logic [7:0] sbv, scv;
        do_write(1'b0, 8'h11, EvIcw1, sbv, scv);
        do_write(1'b1, 8'h08, EvIcw2, sbv, scv);
        n_total++;
        if (sbv !== EvIcw2) $display("FAIL midseq_icw2_b: got %h, want %h", sbv, EvIcw2);
        else n_pass++;
        // Write toward ICW3 whose strobe is cut off by reset.
        @(posedge clock); #1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_bus_in = 8'h04;
        repeat (3) @(posedge clock);
        #1;
        wr_n = 1'b1; cs_n = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if ({ev_a, bus_a, init_a, single_a, ic4_a, isr_a, read_a,
             ev_b, bus_b, init_b, single_b, ic4_b, isr_b, read_b,
             ev_c, bus_c, init_c, single_c, ic4_c, isr_c, read_c} !== 63'd0)
            $display("FAIL midseq_reset: got a=%h b=%h c=%h, want all 0",
                     {ev_a, bus_a, init_a, single_a, ic4_a, isr_a},
                     {ev_b, bus_b, init_b, single_b, ic4_b, isr_b},
                     {ev_c, bus_c, init_c, single_c, ic4_c, isr_c});
        else n_pass++;
        reset = 1'b0;
        sbv = 8'h00; scv = 8'h00;
        repeat (8) begin
            @(negedge clock);
            sbv |= ev_b; scv |= ev_c;
        end
        n_total++;
        if ({sbv, scv} !== 16'h0000)
            $display("FAIL midseq_no_strobe: got b=%h c=%h, want 00 00", sbv, scv);
        else n_pass++;
        do_write(1'b1, 8'h04, EvIgn, sbv, scv);
        n_total++;
        if ({sbv, scv} !== {EvIgn, EvIgn})
            $display("FAIL midseq_ign: got b=%h c=%h, want 80 80", sbv, scv);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_idle_ignored();
        test_single();
        test_ready_ocw();
        test_latency();
        test_reicw1();
        test_cascade();
        test_abort();
        test_reset_midseq();
        repeat (4) @(posedge clock);
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
